dmem_arbiter: RTL and testbench

Two-requester arbiter for the single-port, synchronous data memory behind the CPU's data port. It lets the CPU core (requester 0) and a host/debug loader (requester 1) share one memory. It uses a valid/ready handshake per requester, round-robin fairness with an optional bounded lock for bursts, registered memory-side outputs and tagged read-return. It sits between the core's data port and the data RAM.

---
 rtl/dmem_arbiter.sv | 92 +++++++++
 tb/tb_dmem_arbiter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-requester round-robin arbiter for the single-port data RAM.
// Registered memory strobes, bounded burst lock, tagged read return.
module dmem_arbiter #(
    parameter int WIDTH    = 32,
    parameter int ADDRSIZE = 12,
    parameter int MAXBURST = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req0,
    input  logic                req1,
    input  logic                we0,
    input  logic                we1,
    input  logic [ADDRSIZE-1:0] addr0,
    input  logic [ADDRSIZE-1:0] addr1,
    input  logic [0:WIDTH-1]    wdata0,
    input  logic [0:WIDTH-1]    wdata1,
    input  logic                lock0,
    input  logic                lock1,
    output logic                gnt0,
    output logic                gnt1,
    output logic                rvalid0,
    output logic                rvalid1,
    output logic [0:WIDTH-1]    rdata,
    output logic                mem_en,
    output logic                mem_we,
    output logic [ADDRSIZE-1:0] mem_addr,
    output logic [0:WIDTH-1]    mem_wdata,
    input  logic [0:WIDTH-1]    mem_rdata
);

    localparam int RW = $clog2(MAXBURST + 1);
    localparam logic [RW-1:0] RMAX = RW'(MAXBURST);

    logic          last;
    logic [RW-1:0] run;
    logic          rd_pend;
    logic          rd_id;

    logic lock_last;
    logic keep;
    logic prio;
    logic xfer;
    logic xid;
    logic xwe;

    // run==0 only right after reset, so a stale lock cannot beat requester 0
    always_comb begin
        lock_last = last ? lock1 : lock0;
        keep      = lock_last && (run != '0) && (run < RMAX);
        prio      = keep ? last : ~last;
        gnt0      = ~rst & req0 & (~req1 | ~prio);
        gnt1      = ~rst & req1 & (~req0 | prio);
        xfer      = gnt0 | gnt1;
        xid       = gnt1;
        xwe       = gnt1 ? we1 : we0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            last      <= 1'b1;
            run       <= '0;
            rd_pend   <= 1'b0;
            rd_id     <= 1'b0;
            rvalid0   <= 1'b0;
            rvalid1   <= 1'b0;
        end else begin
            mem_en  <= xfer;
            mem_we  <= xfer & xwe;
            rd_pend <= xfer & ~xwe;
            rvalid0 <= rd_pend & ~rd_id;
            rvalid1 <= rd_pend & rd_id;
            if (xfer) begin
                mem_addr  <= xid ? addr1 : addr0;
                mem_wdata <= xid ? wdata1 : wdata0;
                rd_id     <= xid;
                last      <= xid;
                if (xid == last)
                    run <= (run == RMAX) ? RMAX : run + 1'b1;
                else
                    run <= RW'(1);
            end
        end
    end

    assign rdata = mem_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural single-port RAM.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1, we0, we1, lock0, lock1;
    logic [11:0] addr0, addr1;
    logic [0:31] wdata0, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1;
    logic [0:31] rdata;
    logic        mem_en, mem_we;
    logic [11:0] mem_addr;
    logic [0:31] mem_wdata;
    logic [0:31] mem_rdata;

    logic [0:31] ram [0:4095];
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.WIDTH(32), .ADDRSIZE(12), .MAXBURST(4)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1),
        .wdata0(wdata0), .wdata1(wdata1),
        .lock0(lock0), .lock1(lock1),
        .gnt0(gnt0), .gnt1(gnt1),
        .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata(rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else mem_rdata <= ram[mem_addr];
        end
    end

    task automatic test_reset;
        #1 req0 = 1'b1; req1 = 1'b1;
        #1;
        total++;
        if ({gnt0, gnt1, mem_en, rvalid0} !== 4'b0000) begin
            bad++;
            $display("FAIL in_reset got gnt0/gnt1/mem_en/rvalid0=%b want 0000",
                     {gnt0, gnt1, mem_en, rvalid0});
        end
        rst = 1'b0;
        #1;
        total++;
        if ({gnt0, gnt1} !== 2'b10) begin
            bad++;
            $display("FAIL first_tie got gnt=%b want 10", {gnt0, gnt1});
        end
        req1 = 1'b0; we0 = 1'b0; addr0 = 12'h010;
        @(posedge clk); #1;
        total++;
        if (mem_en !== 1'b1 || mem_addr !== 12'h010) begin
            bad++;
            $display("FAIL pre_reset_read got en=%b addr=%h want 1 010", mem_en, mem_addr);
        end
        rst = 1'b1;
        #1;
        total++;
        if ({gnt0, mem_en, mem_we, rvalid0} !== 4'b0000 || mem_addr !== 12'h000) begin
            bad++;
            $display("FAIL mid_reset got gnt0/en/we/rv=%b addr=%h want 0000 000",
                     {gnt0, mem_en, mem_we, rvalid0}, mem_addr);
        end
        req0 = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            total++;
            if (rvalid0 !== 1'b0 || rvalid1 !== 1'b0) begin
                bad++;
                $display("FAIL dropped_read cyc%0d got rv=%b%b want 00", i, rvalid0, rvalid1);
            end
        end
    endtask

    task automatic test_single_read;
        req0 = 1'b1; we0 = 1'b0; addr0 = 12'h010;
        #1;
        total++;
        if ({gnt0, gnt1} !== 2'b10) begin
            bad++;
            $display("FAIL sr_gnt got gnt=%b want 10", {gnt0, gnt1});
        end
        @(posedge clk); #1 req0 = 1'b0;
        total++;
        if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 12'h010) begin
            bad++;
            $display("FAIL sr_mem got en=%b we=%b addr=%h want 1 0 010", mem_en, mem_we, mem_addr);
        end
        @(posedge clk); #1;
        total++;
        if (rvalid0 !== 1'b1 || rvalid1 !== 1'b0 || rdata !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL sr_data got rv=%b%b rdata=%h want 10 deadbeef", rvalid0, rvalid1, rdata);
        end
        @(posedge clk); #1;
        total++;
        if (rvalid0 !== 1'b0 || mem_en !== 1'b0) begin
            bad++;
            $display("FAIL sr_done got rv0=%b en=%b want 0 0", rvalid0, mem_en);
        end
    endtask

    task automatic test_contention;
        logic        exp1;
        logic [11:0] ea;
        req0 = 1'b1; we0 = 1'b1; addr0 = 12'h100; wdata0 = 32'h0000_0100;
        req1 = 1'b1; we1 = 1'b1; addr1 = 12'h200; wdata1 = 32'h0000_0200;
        for (int i = 0; i < 8; i++) begin
            exp1 = (i % 2 == 0);
            #1;
            total++;
            if (gnt1 !== exp1 || gnt0 !== ~exp1) begin
                bad++;
                $display("FAIL rr_gnt%0d got gnt=%b%b want %b%b", i, gnt0, gnt1, ~exp1, exp1);
            end
            @(posedge clk); #1;
            ea = exp1 ? 12'h200 : 12'h100;
            total++;
            if (mem_en !== 1'b1 || mem_addr !== ea || mem_wdata !== {20'h0, ea}) begin
                bad++;
                $display("FAIL rr_mem%0d got en=%b addr=%h wd=%h want 1 %h", i, mem_en, mem_addr, mem_wdata, ea);
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        @(posedge clk); #1;
        total++;
        if (mem_en !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 12'h100) begin
            bad++;
            $display("FAIL idle got en=%b we=%b addr=%h want 0 0 100", mem_en, mem_we, mem_addr);
        end
    endtask

    task automatic test_lock_bound;
        logic exp1;
        req1 = 1'b1; lock1 = 1'b1; we1 = 1'b1; addr1 = 12'h300; wdata1 = 32'h3;
        #1;
        total++;
        if (gnt1 !== 1'b1) begin
            bad++;
            $display("FAIL lock_first got gnt1=%b want 1", gnt1);
        end
        @(posedge clk); #1;
        req0 = 1'b1; we0 = 1'b1; addr0 = 12'h301; wdata0 = 32'h4;
        for (int i = 0; i < 4; i++) begin
            exp1 = (i < 3);
            #1;
            total++;
            if (gnt1 !== exp1 || gnt0 !== ~exp1) begin
                bad++;
                $display("FAIL lock_run%0d got gnt=%b%b want %b%b", i, gnt0, gnt1, ~exp1, exp1);
            end
            @(posedge clk); #1;
        end
        req0 = 1'b0; req1 = 1'b0; lock1 = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_wr_rd_order;
        req1 = 1'b1; we1 = 1'b1; addr1 = 12'h0A5; wdata1 = 32'h12345678;
        #1;
        total++;
        if (gnt1 !== 1'b1) begin
            bad++;
            $display("FAIL wr_gnt got gnt1=%b want 1", gnt1);
        end
        @(posedge clk); #1;
        req1 = 1'b0;
        req0 = 1'b1; we0 = 1'b0; addr0 = 12'h0A5;
        #1;
        total++;
        if (gnt0 !== 1'b1 || mem_we !== 1'b1 || mem_wdata !== 32'h12345678) begin
            bad++;
            $display("FAIL wr_mem got gnt0=%b we=%b wd=%h want 1 1 12345678", gnt0, mem_we, mem_wdata);
        end
        @(posedge clk); #1 req0 = 1'b0;
        @(posedge clk); #1;
        total++;
        if (rvalid0 !== 1'b1 || rvalid1 !== 1'b0 || rdata !== 32'h12345678) begin
            bad++;
            $display("FAIL wr_rd got rv=%b%b rdata=%h want 10 12345678", rvalid0, rvalid1, rdata);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_lone;
        req0 = 1'b1; lock0 = 1'b1; we0 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            addr0 = 12'h400 + 12'(i);
            wdata0 = 32'(i);
            #1;
            total++;
            if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
                bad++;
                $display("FAIL lone_gnt%0d got gnt=%b%b want 10", i, gnt0, gnt1);
            end
            @(posedge clk); #1;
            total++;
            if (mem_en !== 1'b1 || mem_addr !== 12'h400 + 12'(i)) begin
                bad++;
                $display("FAIL lone_mem%0d got en=%b addr=%h want 1 %h", i, mem_en, mem_addr, 12'h400 + 12'(i));
            end
        end
        req0 = 1'b0; lock0 = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back;
        req1 = 1'b1; we1 = 1'b0; addr1 = 12'h0A5;
        #1;
        total++;
        if (gnt1 !== 1'b1) begin
            bad++;
            $display("FAIL b2b_gnt1 got gnt1=%b want 1", gnt1);
        end
        @(posedge clk); #1;
        req1 = 1'b0;
        req0 = 1'b1; we0 = 1'b0; addr0 = 12'h010;
        #1;
        total++;
        if (gnt0 !== 1'b1) begin
            bad++;
            $display("FAIL b2b_gnt0 got gnt0=%b want 1", gnt0);
        end
        @(posedge clk); #1 req0 = 1'b0;
        total++;
        if (rvalid1 !== 1'b1 || rvalid0 !== 1'b0 || rdata !== 32'h12345678) begin
            bad++;
            $display("FAIL b2b_rv1 got rv=%b%b rdata=%h want 01 12345678", rvalid0, rvalid1, rdata);
        end
        @(posedge clk); #1;
        total++;
        if (rvalid0 !== 1'b1 || rvalid1 !== 1'b0 || rdata !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL b2b_rv0 got rv=%b%b rdata=%h want 10 deadbeef", rvalid0, rvalid1, rdata);
        end
        @(posedge clk); #1;
        total++;
        if (rvalid0 !== 1'b0 || rvalid1 !== 1'b0) begin
            bad++;
            $display("FAIL b2b_idle got rv=%b%b want 00", rvalid0, rvalid1);
        end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) ram[i] = '0;
        ram[12'h010] = 32'hDEADBEEF;
        mem_rdata = '0;
        rst = 1'b1;
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        lock0 = 1'b0; lock1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        repeat (2) @(posedge clk);
        test_reset;
        test_single_read;
        test_contention;
        test_lock_bound;
        test_wr_rd_order;
        test_lone;
        test_back_to_back;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
